// File: rtl/spu_seq_pkg.sv
// spu_seq_pkg: shared types and field layout for the SPU command sequencer.
// Program entry layout is {cap, op, q, operand}.
package spu_seq_pkg;

  localparam int SPU_LAT = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } seq_state_e;

  localparam int CAP_BIT  = 16;
  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int Q_MSB    = 11;
  localparam int Q_LSB    = 8;
  localparam int OPND_MSB = 7;
  localparam int OPND_LSB = 0;

  localparam logic [7:0] SPU_NOP_CMD = 8'h00;

endpackage

// File: rtl/spu_seq_capture_pipe.sv
// spu_seq_capture_pipe: SPU_LAT-deep {cap, index} delay line.
// Travels alongside each issue so the result can be tagged when it returns.
module spu_seq_capture_pipe
  import spu_seq_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          cap_i,
  input  logic [AW-1:0] idx_i,
  output logic          cap_o,
  output logic [AW-1:0] idx_o
);

  logic [SPU_LAT-1:0] cap_q;
  logic [AW-1:0]      idx_q [SPU_LAT];

  // Shift the tag line each cycle; flush drops everything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      cap_q <= '0;
      for (int i = 0; i < SPU_LAT; i++) idx_q[i] <= '0;
    end else begin
      cap_q[0] <= cap_i;
      idx_q[0] <= idx_i;
      for (int i = 1; i < SPU_LAT; i++) begin
        cap_q[i] <= cap_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign cap_o = cap_q[SPU_LAT-1];
  assign idx_o = idx_q[SPU_LAT-1];

endmodule

// File: rtl/spu_cmd_sequencer.sv
// spu_cmd_sequencer: replays a loaded program into the SPU, captures flagged results.
// SPU_SEQ_LOOP_EN: repeat the program loop_count extra passes.
module spu_cmd_sequencer
  import spu_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog_valid,
  output logic          prog_ready,
  input  logic [16:0]   prog_data,
  input  logic          prog_clear,
  input  logic          start,
  input  logic          abort,
  input  logic [3:0]    loop_count,
  output logic          busy,
  output logic          done,
  output logic [7:0]    spu_ui,
  output logic [7:0]    spu_uio,
  output logic          spu_ena,
  input  logic [7:0]    spu_uo,
  output logic          res_valid,
  output logic [7:0]    res_data,
  output logic [AW-1:0] res_index
);

  localparam logic [AW:0] CNT_MAX    = (AW+1)'(DEPTH);
  localparam logic [1:0]  DRAIN_LAST = 2'(SPU_LAT - 1);

  logic [16:0]   mem_q [DEPTH];
  seq_state_e    state_q;
  logic [AW:0]   wr_cnt_q, len_d;
  logic [AW-1:0] rd_ptr_q, nxt_ptr_d;
  logic [1:0]    drain_q;
  logic          busy_q, done_q, ena_q, cap_q;
  logic [7:0]    ui_q, uio_q;
  logic          rv_q;
  logic [7:0]    rd_q;
  logic [AW-1:0] ri_q;
  logic          wr_acc_d, last_d, more_d, flush_d;
  logic [16:0]   first_d, nxt_ent_d;
  logic          pipe_cap;
  logic [AW-1:0] pipe_idx;

`ifdef SPU_SEQ_LOOP_EN
  logic [3:0] loops_q;
  assign more_d = (loops_q != 4'd0);
`else
  logic unused_loop;
  assign unused_loop = ^loop_count;
  assign more_d = 1'b0;
`endif

  // Write acceptance, effective length and next entry to present.
  always_comb begin
    prog_ready = (state_q == IDLE) && (wr_cnt_q < CNT_MAX);
    wr_acc_d   = prog_valid && prog_ready && !prog_clear;
    len_d      = prog_clear ? '0 : wr_cnt_q + (AW+1)'(wr_acc_d);
    first_d    = (wr_acc_d && wr_cnt_q == '0) ? prog_data : mem_q[0];
    last_d     = ({1'b0, rd_ptr_q} == wr_cnt_q - (AW+1)'(1));
    nxt_ptr_d  = last_d ? '0 : rd_ptr_q + AW'(1);
    nxt_ent_d  = mem_q[nxt_ptr_d];
    flush_d    = abort && (state_q == RUN || state_q == DRAIN);
  end

  // Program buffer storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_acc_d) begin
      mem_q[wr_cnt_q[AW-1:0]] <= prog_data;
    end
  end

  // Sequencer FSM with registered SPU drive, busy and done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_cnt_q <= '0;
      rd_ptr_q <= '0;
      drain_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ena_q    <= 1'b0;
      cap_q    <= 1'b0;
      ui_q     <= SPU_NOP_CMD;
      uio_q    <= '0;
`ifdef SPU_SEQ_LOOP_EN
      loops_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          wr_cnt_q <= len_d;
          if (start) begin
            rd_ptr_q <= '0;
`ifdef SPU_SEQ_LOOP_EN
            loops_q  <= loop_count;
`endif
            if (len_d != '0) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              ena_q   <= 1'b1;
              ui_q    <= first_d[OP_MSB:Q_LSB];
              uio_q   <= first_d[OPND_MSB:OPND_LSB];
              cap_q   <= first_d[CAP_BIT];
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort || (last_d && !more_d)) begin
            state_q <= abort ? IDLE : DRAIN;
            busy_q  <= !abort;
            drain_q <= '0;
            ena_q   <= 1'b0;
            cap_q   <= 1'b0;
            ui_q    <= SPU_NOP_CMD;
            uio_q   <= '0;
          end else begin
            rd_ptr_q <= nxt_ptr_d;
            ui_q     <= nxt_ent_d[OP_MSB:Q_LSB];
            uio_q    <= nxt_ent_d[OPND_MSB:OPND_LSB];
            cap_q    <= nxt_ent_d[CAP_BIT];
`ifdef SPU_SEQ_LOOP_EN
            if (last_d) loops_q <= loops_q - 4'd1;
`endif
          end
        end
        DRAIN: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (drain_q == DRAIN_LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  spu_seq_capture_pipe #(.AW(AW)) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_d),
    .cap_i   (ena_q & cap_q),
    .idx_i   (rd_ptr_q),
    .cap_o   (pipe_cap),
    .idx_o   (pipe_idx)
  );

  // Sample the SPU output when a flagged tag emerges from the delay line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rv_q <= 1'b0;
      rd_q <= '0;
      ri_q <= '0;
    end else begin
      rv_q <= pipe_cap && !flush_d;
      if (pipe_cap && !flush_d) begin
        rd_q <= spu_uo;
        ri_q <= pipe_idx;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign spu_ena   = ena_q;
  assign spu_ui    = ui_q;
  assign spu_uio   = uio_q;
  assign res_valid = rv_q;
  assign res_data  = rd_q;
  assign res_index = ri_q;

endmodule

// File: tb/tb_spu_cmd_sequencer.sv
// tb_spu_cmd_sequencer: randomized and directed bench with a cycle-schedule model.
// Honours SPU_SEQ_LOOP_EN when the design is built with it.
module tb_spu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prog_valid = 1'b0;
  logic        prog_ready;
  logic [16:0] prog_data = '0;
  logic        prog_clear = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  loop_count = '0;
  logic        busy, done;
  logic [7:0]  spu_ui, spu_uio;
  logic        spu_ena;
  logic [7:0]  spu_uo = '0;
  logic        res_valid;
  logic [7:0]  res_data;
  logic [3:0]  res_index;

  spu_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .prog_valid(prog_valid), .prog_ready(prog_ready),
    .prog_data(prog_data), .prog_clear(prog_clear),
    .start(start), .abort(abort), .loop_count(loop_count),
    .busy(busy), .done(done),
    .spu_ui(spu_ui), .spu_uio(spu_uio), .spu_ena(spu_ena),
    .spu_uo(spu_uo),
    .res_valid(res_valid), .res_data(res_data), .res_index(res_index)
  );

  always #5 clk = ~clk;

  // Stub SPU: input register on ena, output register one edge later.
  logic [7:0] s_ui = '0, s_uio = '0;
  function automatic logic [7:0] spu_f(input logic [7:0] a, input logic [7:0] b);
    return a ^ b ^ 8'hA5;
  endfunction
  always @(posedge clk) begin
    if (spu_ena) begin
      s_ui  <= spu_ui;
      s_uio <= spu_uio;
    end
    spu_uo <= spu_f(s_ui, s_uio);
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a per-cycle schedule of expected outputs.
  int cyc = 0;
  int cnt = 0;
  int idle_from = 0;
  logic [16:0] prog [16];
  bit         e_ena  [int];
  logic [7:0] e_ui   [int];
  logic [7:0] e_uio  [int];
  logic [7:0] e_rd   [int];
  int         e_ri   [int];
  bit         e_done [int];
  bit         e_busy [int];

  function automatic void purge(input int from);
    for (int k = from; k < from + 600; k++) begin
      e_ena.delete(k); e_ui.delete(k); e_uio.delete(k);
      e_rd.delete(k); e_ri.delete(k);
      e_done.delete(k); e_busy.delete(k);
    end
  endfunction

  function automatic void schedule(input int s);
    int passes, n, j;
    passes = 1;
`ifdef SPU_SEQ_LOOP_EN
    passes = int'(loop_count) + 1;
`endif
    n = cnt * passes;
    if (n == 0) begin
      e_done[s] = 1'b1;
      idle_from = s + 1;
    end else begin
      for (int k = 0; k < n; k++) begin
        j = k % cnt;
        e_ena[s+k] = 1'b1;
        e_ui[s+k]  = prog[j][15:8];
        e_uio[s+k] = prog[j][7:0];
        if (prog[j][16]) begin
          e_rd[s+k+3] = spu_f(prog[j][15:8], prog[j][7:0]);
          e_ri[s+k+3] = j;
        end
      end
      for (int k = 0; k < n + 2; k++) e_busy[s+k] = 1'b1;
      e_done[s+n+2] = 1'b1;
      idle_from = s + n + 3;
    end
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      purge(cyc);
      cnt = 0;
      idle_from = cyc;
    end else if (cyc - 1 >= idle_from) begin
      if (prog_clear) cnt = 0;
      else if (prog_valid && cnt < 16) begin
        prog[cnt] = prog_data;
        cnt++;
      end
      if (start) schedule(cyc);
    end else if (abort && e_busy.exists(cyc - 1)) begin
      purge(cyc);
      idle_from = cyc;
    end
  end

  // Observation logs for directed checks.
  logic [7:0] obs_ui [$];
  logic [7:0] obs_uio [$];
  logic [7:0] obs_rd [$];
  int         obs_ri [$];
  int done_cyc = -1;
  int last_ena = -1;

  // Compare DUT to the model schedule each cycle, away from the edge.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      chk("spu_ena", spu_ena, e_ena.exists(cyc));
      if (e_ena.exists(cyc)) begin
        chk("spu_ui", spu_ui, e_ui[cyc]);
        chk("spu_uio", spu_uio, e_uio[cyc]);
      end
      chk("busy", busy, e_busy.exists(cyc));
      chk("done", done, e_done.exists(cyc));
      chk("res_valid", res_valid, e_rd.exists(cyc));
      if (e_rd.exists(cyc)) begin
        chk("res_data", res_data, e_rd[cyc]);
        chk("res_index", res_index, e_ri[cyc]);
      end
      chk("prog_ready", prog_ready, (cyc >= idle_from) && (cnt < 16));
      if (spu_ena === 1'b1) begin
        obs_ui.push_back(spu_ui);
        obs_uio.push_back(spu_uio);
        last_ena = cyc;
      end
      if (res_valid === 1'b1) begin
        obs_rd.push_back(res_data);
        obs_ri.push_back(int'(res_index));
      end
      if (done === 1'b1) done_cyc = cyc;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs;
    obs_ui.delete(); obs_uio.delete();
    obs_rd.delete(); obs_ri.delete();
    done_cyc = -1;
    last_ena = -1;
  endtask

  task automatic load(input logic [16:0] e);
    prog_valid = 1'b1;
    prog_data  = e;
    tick();
    prog_valid = 1'b0;
  endtask

  task automatic do_clear;
    prog_clear = 1'b1;
    tick();
    prog_clear = 1'b0;
  endtask

  task automatic do_start(output int s);
    start = 1'b1;
    tick();
    s = cyc;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (cyc < idle_from && n < max) begin
      tick();
      n++;
    end
    if (cyc < idle_from) begin
      failures++;
      $display("FAIL idle_timeout: waited %0d cycles", max);
    end
  endtask

  int s;
  int n_exp;

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Three-entry program with two flagged results.
    do_clear();
    load(17'h0_07_35);
    load(17'h1_10_00);
    load(17'h1_30_00);
    clear_obs();
    do_start(s);
    wait_idle(50);
    chk("t1_issues", obs_ui.size(), 3);
    if (obs_ui.size() == 3) begin
      chk("t1_ui0", obs_ui[0], 8'h07);
      chk("t1_uio0", obs_uio[0], 8'h35);
      chk("t1_ui1", obs_ui[1], 8'h10);
      chk("t1_ui2", obs_ui[2], 8'h30);
    end
    chk("t1_nres", obs_rd.size(), 2);
    if (obs_rd.size() == 2) begin
      chk("t1_rd0", obs_rd[0], 8'hB5);
      chk("t1_ri0", obs_ri[0], 1);
      chk("t1_rd1", obs_rd[1], 8'h95);
      chk("t1_ri1", obs_ri[1], 2);
    end
    chk("t1_done_gap", done_cyc - last_ena, 3);

    // Empty program.
    do_clear();
    clear_obs();
    do_start(s);
    wait_idle(10);
    tick();
    chk("t2_done_cyc", done_cyc, s);
    chk("t2_issues", obs_ui.size(), 0);
    chk("t2_nres", obs_rd.size(), 0);

    // Fill the buffer and keep pushing.
    do_clear();
    prog_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      prog_data = {1'b0, 16'(i * 16'h0111)};
      tick();
    end
    chk("t3_ready_full", prog_ready, 1'b0);
    prog_valid = 1'b0;
    loop_count = 4'd0;
    clear_obs();
    do_start(s);
    wait_idle(100);
    chk("t3_issues", obs_ui.size(), 16);

    // Abort on the second RUN cycle, then rerun.
    do_clear();
    for (int i = 0; i < 4; i++) load({1'b1, 8'(8'h41 + i), 8'(i * 3)});
    clear_obs();
    do_start(s);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (8) tick();
    chk("t4_issues", obs_ui.size(), 2);
    chk("t4_nres", obs_rd.size(), 0);
    chk("t4_no_done", done_cyc, -1);
    clear_obs();
    do_start(s);
    wait_idle(50);
    chk("t4_rerun", obs_ui.size(), 4);
    chk("t4_rerun_res", obs_rd.size(), 4);

    // Two-entry program with loop_count=2.
    do_clear();
    load(17'h1_21_0A);
    load(17'h1_52_0B);
    loop_count = 4'd2;
    clear_obs();
    do_start(s);
    wait_idle(50);
`ifdef SPU_SEQ_LOOP_EN
    n_exp = 6;
`else
    n_exp = 2;
`endif
    chk("t5_issues", obs_ui.size(), n_exp);
    chk("t5_nres", obs_rd.size(), n_exp);
    if (obs_ui.size() == n_exp)
      for (int k = 0; k < n_exp; k++)
        chk("t5_alt", obs_ui[k], (k % 2) ? 8'h52 : 8'h21);
    chk("t5_done", done_cyc > 0, 1'b1);
    loop_count = 4'd0;

    // Reset in the middle of RUN.
    do_clear();
    for (int i = 0; i < 4; i++) load({1'b1, 16'h3300 + 16'(i)});
    do_start(s);
    tick();
    rst_n = 1'b0;
    tick();
    chk("t6_busy", busy, 1'b0);
    chk("t6_ena", spu_ena, 1'b0);
    chk("t6_rv", res_valid, 1'b0);
    chk("t6_ready", prog_ready, 1'b1);
    rst_n = 1'b1;
    tick();
    clear_obs();
    do_start(s);
    wait_idle(10);
    chk("t6_empty", obs_ui.size(), 0);

    // Randomized programs with noise and random aborts.
    for (int it = 0; it < 40; it++) begin
      int nl;
      if ($urandom_range(1, 0) == 1) do_clear();
      loop_count = 4'($urandom_range(3, 0));
      nl = $urandom_range(5, 0);
      for (int i = 0; i < nl; i++) begin
        prog_valid = 1'b1;
        prog_data  = 17'($urandom);
        start = (i == nl - 1) && ($urandom_range(3, 0) == 0);
        tick();
        prog_valid = 1'b0;
        start = 1'b0;
        if ($urandom_range(3, 0) == 0) tick();
      end
      start = 1'b1;
      prog_clear = ($urandom_range(7, 0) == 0);
      tick();
      start = 1'b0;
      prog_clear = 1'b0;
      for (int i = 0; i < $urandom_range(12, 0); i++) begin
        abort      = ($urandom_range(9, 0) == 0);
        prog_valid = ($urandom_range(3, 0) == 0);
        prog_data  = 17'($urandom);
        prog_clear = ($urandom_range(7, 0) == 0);
        start      = ($urandom_range(7, 0) == 0);
        tick();
      end
      abort = 1'b0;
      prog_valid = 1'b0;
      prog_clear = 1'b0;
      start = 1'b0;
      wait_idle(400);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
